branch_update_unit: RTL and testbench
=====================================

Name: branch_update_unit

Overview:
- Collects branch-resolution info (brinfo) from the N_BRU ALU execution units and builds the brupdate broadcast that those units and the rest of the core consume.
- Stage b1 carries the resolve and mispredict masks. Stage b2 carries the oldest mispredicting branch's uop and redirect info for the frontend/FTQ.
- Sits between the execution units and the ROB/frontend.

Parameters:
- N_BRU, 2, number of brinfo source ports.
- BR_MASK_W, 20, branch mask width; br_tag width = clog2(BR_MASK_W) = 5.
- ROB_IDX_W, 7, ROB index width.

Ports:
- clock  input  1  core clock.
- reset  input  1  asynchronous active-low reset.
- flush  input  1  pipeline flush; clears all in-flight state.
- rob_head_idx  input  ROB_IDX_W  oldest ROB entry, used for age compare.
- brinfo_valid  input  N_BRU  per-port valid.
- brinfo_mispredict, brinfo_taken, brinfo_uop_is_rvc, brinfo_uop_edge_inst  input  N_BRU each  per-port flags.
- brinfo_uop_br_mask  input  N_BRU*20  per-port branch mask.
- brinfo_uop_br_tag  input  N_BRU*5  per-port branch tag.
- brinfo_uop_ftq_idx, brinfo_uop_pc_lob  input  N_BRU*6 each  FTQ index and PC low bits.
- brinfo_uop_rob_idx  input  N_BRU*7  per-port ROB index.
- brinfo_uop_ldq_idx, brinfo_uop_stq_idx  input  N_BRU*5 each  LDQ/STQ indices.
- brinfo_cfi_type  input  N_BRU*3  CFI type.
- brinfo_pc_sel  input  N_BRU*2  PC select.
- brinfo_target_offset  input  N_BRU*21  target offset.
- b1_resolve_mask  output  20  branches resolved this cycle.
- b1_mispredict_mask  output  20  branches mispredicted this cycle.
- b2_mispredict  output  1  b2 payload valid.
- b2_uop_*  output  as input widths  winning uop fields: is_rvc, br_mask, br_tag, ftq_idx, edge_inst, pc_lob, rob_idx, ldq_idx, stq_idx.
- b2_taken, b2_cfi_type, b2_pc_sel, b2_target_offset  output  1/3/2/21  redirect info.

Behaviour:
- Reset:
  - all outputs 0; all valid registers cleared.
  - Reset is asynchronous, active-low, and may assert at any cycle; every valid bit drops immediately.
- Input qualification (cycle 0), port i accepted iff all of:
  - brinfo_valid[i];
  - !flush;
  - (br_mask[i] & b1_mispredict_mask) == 0. This uses the registered b1 output of the same cycle: a younger branch killed by an older mispredict is dropped.
- Stage 1 register (latency 1):
  - b1_resolve_mask = OR over accepted ports of onehot(br_tag).
  - b1_mispredict_mask = the same OR, restricted to ports with mispredict set.
  - Masks are registered and valid for exactly one cycle.
  - Oldest-select:
    - age_i = (rob_idx_i - rob_head_idx) mod 2^ROB_IDX_W; the smallest age wins among accepted mispredicting ports.
    - Equal age: lower port index wins.
    - The winner's full payload is registered into the s1 payload register.
- Stage 2 register (latency 2):
  - b2_mispredict and payload come from s1, also valid for one cycle.
  - b2_uop_br_mask = s1 br_mask & ~b1_resolve_mask (strip bits resolved in that same cycle).
  - Payload registers hold their value when no new winner arrives; only b2_mispredict is cleared.
- flush:
  - Clears the s1 valids next cycle, so b1 masks read 0.
  - Clears b2_mispredict on the following edge.
  - Payload contents are don't-care.
- Identical br_tag on two ports in one cycle is illegal; the bench asserts on it.
- Boundary cases:
  - ROB wrap: rob_head_idx = 126, rob_idx values 127 and 1 give ages 1 and 3, so 127 wins.
  - No mispredict but a resolve present: only b1_resolve_mask is set.
- Throughput: one brinfo per port per cycle; no backpressure.

Decomposition:
- Package bru_pkg:
  - BR_MASK_W, ROB_IDX_W, BR_TAG_W;
  - brinfo_t struct: uop fields, taken, mispredict, cfi_type, pc_sel, target_offset;
  - cfi_type and pc_sel enums.
- Sub-module rob_age_select: combinational N-way oldest picker over rob_idx and rob_head_idx. Returns the winner index and a found flag.
- Top module: flatten/unflatten, qualification, stage registers.

Test Plan:
- Port0 valid, br_tag = 3, not mispredict -> next cycle b1_resolve_mask = 0x00008, b1_mispredict_mask = 0; b2_mispredict stays 0.
- Port0 tag 2 mispredict with rob_idx 10, port1 tag 5 mispredict with rob_idx 12, rob_head 8 -> b1_mispredict_mask = 0x24; one cycle later b2_mispredict = 1, b2_uop_br_tag = 2, b2_uop_rob_idx = 10.
- Wrap: rob_head = 126, port0 rob_idx 1, port1 rob_idx 127, both mispredicting -> b2_uop_rob_idx = 127.
- Kill: b1_mispredict_mask = 0x4 this cycle, incoming port0 br_mask = 0x4 -> port dropped; next b1_resolve_mask = 0.
- flush asserted with port1 mispredict valid -> b1 masks 0 and b2_mispredict 0 on the following cycles.
- Reset (low) asserted mid-flight between stage 1 and stage 2 -> all outputs 0 asynchronously; after release, no stale b2_mispredict.

Source files
------------

// File: rtl/bru_pkg.sv
// Shared types and widths for the branch update unit.
//   brinfo_t   : one branch-resolution record from an ALU execution unit
//   cfi_type_e : control-flow instruction class
//   pc_sel_e   : frontend PC select for the redirect
package bru_pkg;

  localparam int BR_MASK_W = 20;
  localparam int BR_TAG_W  = $clog2(BR_MASK_W);
  localparam int ROB_IDX_W = 7;
  localparam int FTQ_IDX_W = 6;
  localparam int PC_LOB_W  = 6;
  localparam int LDQ_IDX_W = 5;
  localparam int STQ_IDX_W = 5;
  localparam int TGT_OFF_W = 21;

  typedef enum logic [2:0] {
    CFI_X    = 3'd0,
    CFI_BR   = 3'd1,
    CFI_JAL  = 3'd2,
    CFI_JALR = 3'd3
  } cfi_type_e;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'd0,
    PC_BRJMP = 2'd1,
    PC_JALR  = 2'd2
  } pc_sel_e;

  typedef struct packed {
    logic                  is_rvc;
    logic [BR_MASK_W-1:0]  br_mask;
    logic [BR_TAG_W-1:0]   br_tag;
    logic [FTQ_IDX_W-1:0]  ftq_idx;
    logic                  edge_inst;
    logic [PC_LOB_W-1:0]   pc_lob;
    logic [ROB_IDX_W-1:0]  rob_idx;
    logic [LDQ_IDX_W-1:0]  ldq_idx;
    logic [STQ_IDX_W-1:0]  stq_idx;
    logic                  taken;
    logic                  mispredict;
    cfi_type_e             cfi_type;
    pc_sel_e               pc_sel;
    logic [TGT_OFF_W-1:0]  target_offset;
  } brinfo_t;

  // Tags at or above BR_MASK_W shift out and yield an empty mask.
  function automatic logic [BR_MASK_W-1:0] tag_onehot(input logic [BR_TAG_W-1:0] tag);
    return BR_MASK_W'(1) << tag;
  endfunction

endpackage

// File: rtl/rob_age_select.sv
// Combinational oldest-entry picker.
//   req          : per-port request
//   rob_idx      : flattened per-port ROB indices
//   rob_head_idx : current ROB head, reference point for age
//   found        : at least one request present
//   sel          : index of the oldest requester (lowest port on ties)
module rob_age_select
  import bru_pkg::*;
#(
  parameter int N     = 2,
  parameter int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]           req,
  input  logic [N*ROB_IDX_W-1:0] rob_idx,
  input  logic [ROB_IDX_W-1:0]   rob_head_idx,
  output logic                   found,
  output logic [SEL_W-1:0]       sel
);

  logic [ROB_IDX_W-1:0] age;
  logic [ROB_IDX_W-1:0] best_age;

  // Age is the modular distance from the head, so ROB wrap is handled
  // naturally; strict less-than keeps the lower port on equal age.
  always_comb begin
    found    = 1'b0;
    sel      = '0;
    age      = '0;
    best_age = '1;
    for (int unsigned i = 0; i < N; i++) begin
      age = rob_idx[i*ROB_IDX_W +: ROB_IDX_W] - rob_head_idx;
      if (req[i] && (!found || age < best_age)) begin
        found    = 1'b1;
        sel      = SEL_W'(i);
        best_age = age;
      end
    end
  end

endmodule

// File: rtl/branch_update_unit.sv
// Branch update unit: merges per-ALU brinfo into the brupdate broadcast.
//   clock, reset (async active-low), flush
//   rob_head_idx        : ROB head for age comparison
//   brinfo_*            : flattened per-port branch resolution inputs
//   b1_resolve_mask     : tags resolved, one cycle after input
//   b1_mispredict_mask  : tags mispredicted, one cycle after input
//   b2_*                : oldest mispredict payload, two cycles after input
module branch_update_unit
  import bru_pkg::*;
#(
  parameter int N_BRU = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [ROB_IDX_W-1:0]          rob_head_idx,
  input  logic [N_BRU-1:0]              brinfo_valid,
  input  logic [N_BRU-1:0]              brinfo_mispredict,
  input  logic [N_BRU-1:0]              brinfo_taken,
  input  logic [N_BRU-1:0]              brinfo_uop_is_rvc,
  input  logic [N_BRU-1:0]              brinfo_uop_edge_inst,
  input  logic [N_BRU*BR_MASK_W-1:0]    brinfo_uop_br_mask,
  input  logic [N_BRU*BR_TAG_W-1:0]     brinfo_uop_br_tag,
  input  logic [N_BRU*FTQ_IDX_W-1:0]    brinfo_uop_ftq_idx,
  input  logic [N_BRU*PC_LOB_W-1:0]     brinfo_uop_pc_lob,
  input  logic [N_BRU*ROB_IDX_W-1:0]    brinfo_uop_rob_idx,
  input  logic [N_BRU*LDQ_IDX_W-1:0]    brinfo_uop_ldq_idx,
  input  logic [N_BRU*STQ_IDX_W-1:0]    brinfo_uop_stq_idx,
  input  logic [N_BRU*3-1:0]            brinfo_cfi_type,
  input  logic [N_BRU*2-1:0]            brinfo_pc_sel,
  input  logic [N_BRU*TGT_OFF_W-1:0]    brinfo_target_offset,
  output logic [BR_MASK_W-1:0]          b1_resolve_mask,
  output logic [BR_MASK_W-1:0]          b1_mispredict_mask,
  output logic                          b2_mispredict,
  output logic                          b2_uop_is_rvc,
  output logic [BR_MASK_W-1:0]          b2_uop_br_mask,
  output logic [BR_TAG_W-1:0]           b2_uop_br_tag,
  output logic [FTQ_IDX_W-1:0]          b2_uop_ftq_idx,
  output logic                          b2_uop_edge_inst,
  output logic [PC_LOB_W-1:0]           b2_uop_pc_lob,
  output logic [ROB_IDX_W-1:0]          b2_uop_rob_idx,
  output logic [LDQ_IDX_W-1:0]          b2_uop_ldq_idx,
  output logic [STQ_IDX_W-1:0]          b2_uop_stq_idx,
  output logic                          b2_taken,
  output logic [2:0]                    b2_cfi_type,
  output logic [1:0]                    b2_pc_sel,
  output logic [TGT_OFF_W-1:0]          b2_target_offset
);

  localparam int SEL_W = (N_BRU > 1) ? $clog2(N_BRU) : 1;

  brinfo_t              bi [N_BRU];
  logic [N_BRU-1:0]     accept;
  logic [N_BRU-1:0]     mp_req;
  logic [BR_MASK_W-1:0] resolve_d;
  logic [BR_MASK_W-1:0] mispredict_d;
  logic                 found;
  logic [SEL_W-1:0]     sel;

  logic                 s1_valid;
  brinfo_t              s1_q;
  brinfo_t              s1_strip;
  logic                 b2_valid;
  brinfo_t              b2_q;

  always_comb begin
    for (int unsigned i = 0; i < N_BRU; i++) begin
      bi[i].is_rvc        = brinfo_uop_is_rvc[i];
      bi[i].br_mask       = brinfo_uop_br_mask[i*BR_MASK_W +: BR_MASK_W];
      bi[i].br_tag        = brinfo_uop_br_tag[i*BR_TAG_W +: BR_TAG_W];
      bi[i].ftq_idx       = brinfo_uop_ftq_idx[i*FTQ_IDX_W +: FTQ_IDX_W];
      bi[i].edge_inst     = brinfo_uop_edge_inst[i];
      bi[i].pc_lob        = brinfo_uop_pc_lob[i*PC_LOB_W +: PC_LOB_W];
      bi[i].rob_idx       = brinfo_uop_rob_idx[i*ROB_IDX_W +: ROB_IDX_W];
      bi[i].ldq_idx       = brinfo_uop_ldq_idx[i*LDQ_IDX_W +: LDQ_IDX_W];
      bi[i].stq_idx       = brinfo_uop_stq_idx[i*STQ_IDX_W +: STQ_IDX_W];
      bi[i].taken         = brinfo_taken[i];
      bi[i].mispredict    = brinfo_mispredict[i];
      bi[i].cfi_type      = cfi_type_e'(brinfo_cfi_type[i*3 +: 3]);
      bi[i].pc_sel        = pc_sel_e'(brinfo_pc_sel[i*2 +: 2]);
      bi[i].target_offset = brinfo_target_offset[i*TGT_OFF_W +: TGT_OFF_W];
    end
  end

  // A port is dropped when its branch depends on a mispredict that is
  // being broadcast right now (killed younger branch).
  always_comb begin
    accept       = '0;
    mp_req       = '0;
    resolve_d    = '0;
    mispredict_d = '0;
    for (int unsigned i = 0; i < N_BRU; i++) begin
      accept[i] = brinfo_valid[i] && !flush &&
                  ((bi[i].br_mask & b1_mispredict_mask) == '0);
      if (accept[i]) begin
        resolve_d |= tag_onehot(bi[i].br_tag);
        if (bi[i].mispredict) begin
          mp_req[i]     = 1'b1;
          mispredict_d |= tag_onehot(bi[i].br_tag);
        end
      end
    end
  end

  rob_age_select #(
    .N     (N_BRU),
    .SEL_W (SEL_W)
  ) u_age_sel (
    .req          (mp_req),
    .rob_idx      (brinfo_uop_rob_idx),
    .rob_head_idx (rob_head_idx),
    .found        (found),
    .sel          (sel)
  );

  // Branches resolved alongside the winner are no longer outstanding.
  always_comb begin
    s1_strip         = s1_q;
    s1_strip.br_mask = s1_q.br_mask & ~b1_resolve_mask;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      b1_resolve_mask    <= '0;
      b1_mispredict_mask <= '0;
      s1_valid           <= 1'b0;
      s1_q               <= '0;
      b2_valid           <= 1'b0;
      b2_q               <= '0;
    end else begin
      b1_resolve_mask    <= resolve_d;
      b1_mispredict_mask <= mispredict_d;
      s1_valid           <= found;
      if (found) begin
        s1_q <= bi[sel];
      end
      b2_valid <= s1_valid && !flush;
      if (s1_valid) begin
        b2_q <= s1_strip;
      end
    end
  end

  // Winners are always mispredicting, so the held flag gates only after reset.
  assign b2_mispredict    = b2_valid & b2_q.mispredict;
  assign b2_uop_is_rvc    = b2_q.is_rvc;
  assign b2_uop_br_mask   = b2_q.br_mask;
  assign b2_uop_br_tag    = b2_q.br_tag;
  assign b2_uop_ftq_idx   = b2_q.ftq_idx;
  assign b2_uop_edge_inst = b2_q.edge_inst;
  assign b2_uop_pc_lob    = b2_q.pc_lob;
  assign b2_uop_rob_idx   = b2_q.rob_idx;
  assign b2_uop_ldq_idx   = b2_q.ldq_idx;
  assign b2_uop_stq_idx   = b2_q.stq_idx;
  assign b2_taken         = b2_q.taken;
  assign b2_cfi_type      = b2_q.cfi_type;
  assign b2_pc_sel        = b2_q.pc_sel;
  assign b2_target_offset = b2_q.target_offset;

endmodule

// File: tb/tb_branch_update_unit.sv
module tb_branch_update_unit;
  import bru_pkg::*;

  localparam int N = 2;

  logic                      clock;
  logic                      reset;
  logic                      flush;
  logic [ROB_IDX_W-1:0]      rob_head_idx;
  logic [N-1:0]              brinfo_valid, brinfo_mispredict, brinfo_taken;
  logic [N-1:0]              brinfo_uop_is_rvc, brinfo_uop_edge_inst;
  logic [N*BR_MASK_W-1:0]    brinfo_uop_br_mask;
  logic [N*BR_TAG_W-1:0]     brinfo_uop_br_tag;
  logic [N*FTQ_IDX_W-1:0]    brinfo_uop_ftq_idx;
  logic [N*PC_LOB_W-1:0]     brinfo_uop_pc_lob;
  logic [N*ROB_IDX_W-1:0]    brinfo_uop_rob_idx;
  logic [N*LDQ_IDX_W-1:0]    brinfo_uop_ldq_idx;
  logic [N*STQ_IDX_W-1:0]    brinfo_uop_stq_idx;
  logic [N*3-1:0]            brinfo_cfi_type;
  logic [N*2-1:0]            brinfo_pc_sel;
  logic [N*TGT_OFF_W-1:0]    brinfo_target_offset;
  logic [BR_MASK_W-1:0]      b1_resolve_mask, b1_mispredict_mask;
  logic                      b2_mispredict, b2_uop_is_rvc, b2_uop_edge_inst, b2_taken;
  logic [BR_MASK_W-1:0]      b2_uop_br_mask;
  logic [BR_TAG_W-1:0]       b2_uop_br_tag;
  logic [FTQ_IDX_W-1:0]      b2_uop_ftq_idx;
  logic [PC_LOB_W-1:0]       b2_uop_pc_lob;
  logic [ROB_IDX_W-1:0]      b2_uop_rob_idx;
  logic [LDQ_IDX_W-1:0]      b2_uop_ldq_idx;
  logic [STQ_IDX_W-1:0]      b2_uop_stq_idx;
  logic [2:0]                b2_cfi_type;
  logic [1:0]                b2_pc_sel;
  logic [TGT_OFF_W-1:0]      b2_target_offset;

  branch_update_unit #(.N_BRU(N)) dut (
    .clock                (clock),
    .reset                (reset),
    .flush                (flush),
    .rob_head_idx         (rob_head_idx),
    .brinfo_valid         (brinfo_valid),
    .brinfo_mispredict    (brinfo_mispredict),
    .brinfo_taken         (brinfo_taken),
    .brinfo_uop_is_rvc    (brinfo_uop_is_rvc),
    .brinfo_uop_edge_inst (brinfo_uop_edge_inst),
    .brinfo_uop_br_mask   (brinfo_uop_br_mask),
    .brinfo_uop_br_tag    (brinfo_uop_br_tag),
    .brinfo_uop_ftq_idx   (brinfo_uop_ftq_idx),
    .brinfo_uop_pc_lob    (brinfo_uop_pc_lob),
    .brinfo_uop_rob_idx   (brinfo_uop_rob_idx),
    .brinfo_uop_ldq_idx   (brinfo_uop_ldq_idx),
    .brinfo_uop_stq_idx   (brinfo_uop_stq_idx),
    .brinfo_cfi_type      (brinfo_cfi_type),
    .brinfo_pc_sel        (brinfo_pc_sel),
    .brinfo_target_offset (brinfo_target_offset),
    .b1_resolve_mask      (b1_resolve_mask),
    .b1_mispredict_mask   (b1_mispredict_mask),
    .b2_mispredict        (b2_mispredict),
    .b2_uop_is_rvc        (b2_uop_is_rvc),
    .b2_uop_br_mask       (b2_uop_br_mask),
    .b2_uop_br_tag        (b2_uop_br_tag),
    .b2_uop_ftq_idx       (b2_uop_ftq_idx),
    .b2_uop_edge_inst     (b2_uop_edge_inst),
    .b2_uop_pc_lob        (b2_uop_pc_lob),
    .b2_uop_rob_idx       (b2_uop_rob_idx),
    .b2_uop_ldq_idx       (b2_uop_ldq_idx),
    .b2_uop_stq_idx       (b2_uop_stq_idx),
    .b2_taken             (b2_taken),
    .b2_cfi_type          (b2_cfi_type),
    .b2_pc_sel            (b2_pc_sel),
    .b2_target_offset     (b2_target_offset)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int unsigned rvc, mask, tag, ftq, edge_i, pclob, rob, ldq, stq, taken, cfi, psel, tgt;
  } pay_t;

  // Stimulus for the current cycle.
  pay_t        in_p [N];
  bit          in_v [N];
  bit          in_mp[N];
  bit          in_flush;
  int unsigned in_head;

  // Reference model state: what the outputs should show after the last edge.
  int unsigned e_res, e_mis;
  bit          e_s1_v, e_b2_v;
  pay_t        e_s1, e_b2;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic pay_t rnd_pay();
    pay_t p;
    p.rvc    = $urandom % 2;
    p.mask   = $urandom & $urandom & $urandom & 32'hFFFFF;
    p.tag    = $urandom % 20;
    p.ftq    = $urandom % 64;
    p.edge_i = $urandom % 2;
    p.pclob  = $urandom % 64;
    p.rob    = $urandom % 128;
    p.ldq    = $urandom % 32;
    p.stq    = $urandom % 32;
    p.taken  = $urandom % 2;
    p.cfi    = $urandom % 4;
    p.psel   = $urandom % 3;
    p.tgt    = $urandom % (1 << 21);
    return p;
  endfunction

  task automatic clear_inputs();
    for (int i = 0; i < N; i++) begin
      in_v[i]  = 1'b0;
      in_mp[i] = 1'b0;
      in_p[i]  = rnd_pay();
    end
    in_flush = 1'b0;
  endtask

  task automatic set_port(input int p, input bit mp, input int unsigned tag,
                          input int unsigned mask, input int unsigned rob);
    in_p[p]      = rnd_pay();
    in_v[p]      = 1'b1;
    in_mp[p]     = mp;
    in_p[p].tag  = tag;
    in_p[p].mask = mask;
    in_p[p].rob  = rob;
  endtask

  task automatic drive();
    if (in_v[0] && in_v[1]) begin
      checks++;
      assert (in_p[0].tag != in_p[1].tag) else begin
        errors++;
        $error("FAIL stim_dup_tag observed=%0d expected=distinct", in_p[0].tag);
      end
    end
    flush        = in_flush;
    rob_head_idx = ROB_IDX_W'(in_head);
    for (int i = 0; i < N; i++) begin
      brinfo_valid[i]         = in_v[i];
      brinfo_mispredict[i]    = in_mp[i];
      brinfo_taken[i]         = in_p[i].taken[0];
      brinfo_uop_is_rvc[i]    = in_p[i].rvc[0];
      brinfo_uop_edge_inst[i] = in_p[i].edge_i[0];
      brinfo_uop_br_mask[i*BR_MASK_W +: BR_MASK_W]     = BR_MASK_W'(in_p[i].mask);
      brinfo_uop_br_tag[i*BR_TAG_W +: BR_TAG_W]        = BR_TAG_W'(in_p[i].tag);
      brinfo_uop_ftq_idx[i*FTQ_IDX_W +: FTQ_IDX_W]     = FTQ_IDX_W'(in_p[i].ftq);
      brinfo_uop_pc_lob[i*PC_LOB_W +: PC_LOB_W]        = PC_LOB_W'(in_p[i].pclob);
      brinfo_uop_rob_idx[i*ROB_IDX_W +: ROB_IDX_W]     = ROB_IDX_W'(in_p[i].rob);
      brinfo_uop_ldq_idx[i*LDQ_IDX_W +: LDQ_IDX_W]     = LDQ_IDX_W'(in_p[i].ldq);
      brinfo_uop_stq_idx[i*STQ_IDX_W +: STQ_IDX_W]     = STQ_IDX_W'(in_p[i].stq);
      brinfo_cfi_type[i*3 +: 3]                        = 3'(in_p[i].cfi);
      brinfo_pc_sel[i*2 +: 2]                          = 2'(in_p[i].psel);
      brinfo_target_offset[i*TGT_OFF_W +: TGT_OFF_W]   = TGT_OFF_W'(in_p[i].tgt);
    end
  endtask

  task automatic model_reset();
    e_res  = 0;
    e_mis  = 0;
    e_s1_v = 1'b0;
    e_b2_v = 1'b0;
  endtask

  // One clock edge of the specified behaviour, using this cycle's inputs.
  task automatic model_step();
    int unsigned nres = 0, nmis = 0, age, best_age = 0;
    int          best = -1;
    for (int i = 0; i < N; i++) begin
      if (in_v[i] && !in_flush && ((in_p[i].mask & e_mis) == 0)) begin
        nres |= (1 << in_p[i].tag);
        if (in_mp[i]) begin
          nmis |= (1 << in_p[i].tag);
          age = (in_p[i].rob + 128 - in_head) % 128;
          if (best < 0 || age < best_age) begin
            best     = i;
            best_age = age;
          end
        end
      end
    end
    e_b2_v = e_s1_v && !in_flush;
    if (e_s1_v) begin
      e_b2      = e_s1;
      e_b2.mask = e_s1.mask & ~e_res & 32'hFFFFF;
    end
    e_s1_v = (best >= 0);
    if (best >= 0) e_s1 = in_p[best];
    e_res = nres;
    e_mis = nmis;
  endtask

  task automatic check_outputs();
    chk("b1_resolve_mask", 32'(b1_resolve_mask), e_res);
    chk("b1_mispredict_mask", 32'(b1_mispredict_mask), e_mis);
    chk("b2_mispredict", 32'(b2_mispredict), 32'(e_b2_v));
    if (e_b2_v) begin
      chk("b2_uop_is_rvc", 32'(b2_uop_is_rvc), e_b2.rvc);
      chk("b2_uop_br_mask", 32'(b2_uop_br_mask), e_b2.mask);
      chk("b2_uop_br_tag", 32'(b2_uop_br_tag), e_b2.tag);
      chk("b2_uop_ftq_idx", 32'(b2_uop_ftq_idx), e_b2.ftq);
      chk("b2_uop_edge_inst", 32'(b2_uop_edge_inst), e_b2.edge_i);
      chk("b2_uop_pc_lob", 32'(b2_uop_pc_lob), e_b2.pclob);
      chk("b2_uop_rob_idx", 32'(b2_uop_rob_idx), e_b2.rob);
      chk("b2_uop_ldq_idx", 32'(b2_uop_ldq_idx), e_b2.ldq);
      chk("b2_uop_stq_idx", 32'(b2_uop_stq_idx), e_b2.stq);
      chk("b2_taken", 32'(b2_taken), e_b2.taken);
      chk("b2_cfi_type", 32'(b2_cfi_type), e_b2.cfi);
      chk("b2_pc_sel", 32'(b2_pc_sel), e_b2.psel);
      chk("b2_target_offset", 32'(b2_target_offset), e_b2.tgt);
    end
  endtask

  task automatic step();
    drive();
    @(posedge clock);
    model_step();
    #1;
    check_outputs();
  endtask

  initial begin
    int unsigned t0;

    reset   = 1'b0;
    in_head = 0;
    clear_inputs();
    model_reset();
    drive();
    #12;
    chk("reset_b1_resolve", 32'(b1_resolve_mask), 0);
    chk("reset_b1_mispredict", 32'(b1_mispredict_mask), 0);
    chk("reset_b2_mispredict", 32'(b2_mispredict), 0);
    chk("reset_b2_rob_idx", 32'(b2_uop_rob_idx), 0);
    chk("reset_b2_target", 32'(b2_target_offset), 0);
    @(negedge clock);
    reset = 1'b1;

    // Resolve only, no mispredict.
    set_port(0, 1'b0, 3, 0, 5);
    step();
    chk("tp1_resolve", 32'(b1_resolve_mask), 32'h8);
    chk("tp1_mispredict", 32'(b1_mispredict_mask), 0);
    clear_inputs();
    step();
    chk("tp1_b2", 32'(b2_mispredict), 0);

    // Two mispredicts, older on port 0.
    in_head = 8;
    set_port(0, 1'b1, 2, 0, 10);
    set_port(1, 1'b1, 5, 0, 12);
    step();
    chk("tp2_mispredict", 32'(b1_mispredict_mask), 32'h24);
    clear_inputs();
    step();
    chk("tp2_b2", 32'(b2_mispredict), 1);
    chk("tp2_tag", 32'(b2_uop_br_tag), 2);
    chk("tp2_rob", 32'(b2_uop_rob_idx), 10);

    // ROB wrap: 127 is older than 1 with head 126.
    in_head = 126;
    set_port(0, 1'b1, 4, 0, 1);
    set_port(1, 1'b1, 9, 0, 127);
    step();
    clear_inputs();
    step();
    chk("wrap_rob", 32'(b2_uop_rob_idx), 127);
    chk("wrap_tag", 32'(b2_uop_br_tag), 9);

    // Equal age: port 0 wins.
    set_port(0, 1'b1, 12, 0, 40);
    set_port(1, 1'b1, 13, 0, 40);
    step();
    clear_inputs();
    step();
    chk("tie_tag", 32'(b2_uop_br_tag), 12);

    // Kill: younger branch under the broadcast mispredict is dropped.
    set_port(0, 1'b1, 2, 0, 20);
    step();
    clear_inputs();
    set_port(0, 1'b0, 7, 32'h4, 21);
    step();
    chk("kill_resolve", 32'(b1_resolve_mask), 0);
    clear_inputs();
    step();

    // Winner's mask is stripped of tags resolved in the same cycle.
    set_port(0, 1'b1, 6, 32'h10, 20);
    set_port(1, 1'b0, 4, 0, 22);
    step();
    clear_inputs();
    step();
    chk("strip_mask", 32'(b2_uop_br_mask), 0);

    // Flush with a mispredict present.
    set_port(1, 1'b1, 8, 0, 30);
    in_flush = 1'b1;
    step();
    chk("flush_resolve", 32'(b1_resolve_mask), 0);
    chk("flush_mispredict", 32'(b1_mispredict_mask), 0);
    clear_inputs();
    step();
    chk("flush_b2", 32'(b2_mispredict), 0);

    // Flush one cycle behind a mispredict kills it before stage 2.
    set_port(0, 1'b1, 10, 0, 31);
    step();
    clear_inputs();
    in_flush = 1'b1;
    step();
    chk("flush_inflight_b2", 32'(b2_mispredict), 0);
    clear_inputs();
    step();

    // Asynchronous reset between stage 1 and stage 2.
    set_port(0, 1'b1, 11, 0, 33);
    step();
    #2;
    reset = 1'b0;
    #1;
    chk("areset_b1_resolve", 32'(b1_resolve_mask), 0);
    chk("areset_b1_mispredict", 32'(b1_mispredict_mask), 0);
    chk("areset_b2", 32'(b2_mispredict), 0);
    chk("areset_b2_tag", 32'(b2_uop_br_tag), 0);
    model_reset();
    clear_inputs();
    @(posedge clock);
    #1;
    reset = 1'b1;
    step();
    chk("post_reset_b2", 32'(b2_mispredict), 0);
    step();
    chk("post_reset_b2_late", 32'(b2_mispredict), 0);

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      in_flush = ($urandom % 16) == 0;
      in_head  = $urandom % 128;
      for (int i = 0; i < N; i++) begin
        in_p[i]  = rnd_pay();
        in_v[i]  = ($urandom % 4) != 0;
        in_mp[i] = $urandom % 2;
        if (($urandom % 4) == 0) in_p[i].mask |= e_mis;
      end
      t0 = $urandom % 20;
      in_p[0].tag = t0;
      in_p[1].tag = (t0 + 1 + $urandom % 19) % 20;
      if (($urandom % 4) == 0) in_p[1].rob = in_p[0].rob;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
